// File: rtl/out_uart_tx_if.sv
// out_uart_tx_if: character strobe bus from the core into the UART output stage.
//   out_en   : single-cycle strobe, one character per asserted cycle
//   out_data : character byte, meaningful only while out_en=1
// Modports: master (core side, drives) and slave (UART side, samples).
interface out_uart_tx_if;
  logic       out_en;
  logic [7:0] out_data;

  modport master (output out_en, output out_data);
  modport slave  (input out_en, input out_data);
endinterface

// File: rtl/out_uart_tx.sv
// out_uart_tx: output stage behind the core. Buffers character strobes in a circular FIFO
// and serialises them as 8N1 UART frames. The core cannot be stalled, so a push into a full
// FIFO (with no pop on that edge) is dropped and the sticky overflow flag is raised.
// Optional even-parity bit (8E1) when the macro OUT_UART_PARITY_EN is defined.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   core       : out_uart_tx_if.slave, out_en/out_data character strobe
//   tx         : registered UART line, idle high
//   busy       : FSM not idle or FIFO non-empty (combinational)
//   fifo_count : bytes currently buffered
//   overflow   : sticky, a byte was dropped because the FIFO was full
module out_uart_tx #(
  parameter int unsigned CLKS_PER_BIT    = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  out_uart_tx_if.slave             core,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam logic [FIFO_DEPTH_LOG2:0] DepthCnt = (FIFO_DEPTH_LOG2 + 1)'(Depth);
  localparam logic [CntW-1:0]          LastClk  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef OUT_UART_PARITY_EN
    , StParity
`endif
  } state_e;

  // FIFO storage and pointers
  logic [7:0]                 mem [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       overflow_q;
  logic                       full, empty, push, pop;
  logic [7:0]                 head;

  // Serialiser state
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_done;
`ifdef OUT_UART_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push  = core.out_en && (!full || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
      if (core.out_en && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset; contents are only read when count is non-zero.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= core.out_data;
  end

  assign bit_done = (cnt_q == LastClk);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef OUT_UART_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef OUT_UART_PARITY_EN
      StParity: begin
        tx_d = parity_q;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued frames stay contiguous.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef OUT_UART_PARITY_EN
    if (pop) parity_d = ^head;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef OUT_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef OUT_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || !empty;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
